// File: rtl/prim_reqack_arb_pkg.sv
// Shared types and helpers for the req/ack arbiter.
package prim_reqack_arb_pkg;

    // Arbiter FSM: IDLE picks a grantee, ACTIVE waits for the downstream ack.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_e;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prim_reqack_arb_rr.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping at NumReq-1.
module prim_reqack_arb_rr
    import prim_reqack_arb_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdxW   = width_of(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   rr_ptr,
    output logic              valid,
    output logic [IdxW-1:0]   idx
);

    localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NumReq);

    logic [NumReq-1:0] req_rot;  // req rotated so rr_ptr lands on bit 0
    logic [IdxW:0]     off;      // winning offset from rr_ptr
    logic [IdxW:0]     sum;      // rr_ptr + off, before wrapping

    assign req_rot = NumReq'({req, req} >> rr_ptr);

    // Priority-encode the rotated vector: lowest offset wins.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see
        // earlier results (valid gates the remaining loop iterations).
        valid = 1'b0;
        off   = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (!valid && req_rot[i]) begin
                valid = 1'b1;
                off   = (IdxW+1)'(i);
            end
        end
    end

    assign sum = {1'b0, rr_ptr} + off;
    assign idx = (sum >= NumReqW) ? IdxW'(sum - NumReqW) : IdxW'(sum);

endmodule

// File: rtl/prim_reqack_arb.sv
// Round-robin arbiter funnelling NumReq level requesters onto one req/ack
// synchronizer, with a status-only watchdog on the outstanding handshake.
module prim_reqack_arb
    import prim_reqack_arb_pkg::*;
#(
    parameter  int NumReq        = 4,
    parameter  int TimeoutCycles = 1024,
    localparam int IdxW          = width_of(NumReq),
    localparam int CntW          = width_of(TimeoutCycles + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] ack_o,
    output logic              sync_req_o,
    input  logic              sync_ack_i,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam logic [CntW-1:0] WdMax   = CntW'(TimeoutCycles);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    arb_state_e      state;
    logic [IdxW-1:0] gnt_idx;
    logic [IdxW-1:0] rr_ptr;
    logic [CntW-1:0] wd_cnt;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic            done;        // downstream handshake completes this cycle

    prim_reqack_arb_rr #(
        .NumReq (NumReq)
    ) u_rr (
        .req    (req_i),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // sync_ack_i only matters while a handshake is outstanding.
    assign done = (state == ACTIVE) && sync_ack_i;

    // FSM: grant in IDLE, hold the downstream request until acked, run watchdog.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: flops use non-blocking '<=' so every register samples the
        // pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state   <= IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx <= pick_idx;
                        wd_cnt  <= '0;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (wd_cnt != WdMax) begin
                        wd_cnt <= wd_cnt + CntW'(1);
                    end
                    if (sync_ack_i) begin
                        state  <= IDLE;
                        rr_ptr <= (gnt_idx == LastIdx) ? '0 : gnt_idx + IdxW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forward the downstream ack to the grantee, but only if it still asks.
    always_comb begin
        // NOTE: the default assignment first keeps this block latch-free.
        ack_o = '0;
        if (done) begin
            ack_o[gnt_idx] = req_i[gnt_idx];
        end
    end

    assign sync_req_o = (state == ACTIVE);
    assign busy_o     = (state == ACTIVE);
    assign gnt_idx_o  = gnt_idx;
    assign timeout_o  = (TimeoutCycles != 0) && (state == ACTIVE) && (wd_cnt == WdMax);

endmodule

// File: tb/tb_prim_reqack_arb.sv
// Directed bench for prim_reqack_arb (NumReq=4, TimeoutCycles=8).
// Each test starts just after a rising edge, in IDLE, with inputs at zero;
// inputs change 1 time unit after the edge and outputs are sampled 1 unit later.
module tb_prim_reqack_arb;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] req_i;
    logic [3:0] ack_o;
    logic       sync_req_o;
    logic       sync_ack_i;
    logic [1:0] gnt_idx_o;
    logic       busy_o;
    logic       timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    prim_reqack_arb #(
        .NumReq        (4),
        .TimeoutCycles (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .ack_o      (ack_o),
        .sync_req_o (sync_req_o),
        .sync_ack_i (sync_ack_i),
        .gnt_idx_o  (gnt_idx_o),
        .busy_o     (busy_o),
        .timeout_o  (timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni     = 1'b0;
        req_i      = 4'b0000;
        sync_ack_i = 1'b0;
        #3;
        checks++;
        if ({sync_req_o, busy_o, timeout_o, ack_o, gnt_idx_o} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b busy=%b to=%b ack=%b gnt=%0d want all 0",
                     sync_req_o, busy_o, timeout_o, ack_o, gnt_idx_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Lone requester 2, ack in cycle 5; then rr_ptr=3 shows as a grant to 3 over 0.
    task automatic test_single();
        logic [3:0] exp_ack;
        req_i = 4'b0100;
        #1;
        checks++;
        if (sync_req_o !== 1'b0) begin
            errors++;
            $display("FAIL single_latency c0: sync_req_o=%b want 0", sync_req_o);
        end
        for (int c = 1; c <= 5; c++) begin
            tick();
            sync_ack_i = (c == 5);
            exp_ack    = (c == 5) ? 4'b0100 : 4'b0000;
            #1;
            checks++;
            if (sync_req_o !== 1'b1 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL single_req c%0d: sync_req_o=%b busy_o=%b want 1 1", c, sync_req_o, busy_o);
            end
            checks++;
            if (gnt_idx_o !== 2'd2) begin
                errors++;
                $display("FAIL single_gnt c%0d: gnt_idx_o=%0d want 2", c, gnt_idx_o);
            end
            checks++;
            if (ack_o !== exp_ack) begin
                errors++;
                $display("FAIL single_ack c%0d: ack_o=%b want %b", c, ack_o, exp_ack);
            end
        end
        tick();
        sync_ack_i = 1'b0;
        req_i      = 4'b1001;
        #1;
        checks++;
        if (sync_req_o !== 1'b0 || ack_o !== 4'b0000) begin
            errors++;
            $display("FAIL single_idle c6: sync_req_o=%b ack_o=%b want 0 0000", sync_req_o, ack_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || gnt_idx_o !== 2'd3) begin
            errors++;
            $display("FAIL single_rrptr: busy_o=%b gnt_idx_o=%0d want 1 3", busy_o, gnt_idx_o);
        end
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 4'b1000) begin
            errors++;
            $display("FAIL single_rrptr_ack: ack_o=%b want 1000", ack_o);
        end
        tick();
        sync_ack_i = 1'b0;
        req_i      = 4'b0000;
    endtask

    // All requesters held, ack two cycles after each rise: order 0,1,2,3,0.
    task automatic test_round_robin();
        logic [1:0] exp_gnt;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 2'(g % 4);
            req_i   = 4'b1111;
            #1;
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap g%0d: busy_o=%b want 0", g, busy_o);
            end
            tick();
            checks++;
            if (busy_o !== 1'b1 || gnt_idx_o !== exp_gnt) begin
                errors++;
                $display("FAIL rr_gnt g%0d: busy_o=%b gnt_idx_o=%0d want 1 %0d", g, busy_o, gnt_idx_o, exp_gnt);
            end
            tick();
            checks++;
            if (sync_req_o !== 1'b1 || ack_o !== 4'b0000) begin
                errors++;
                $display("FAIL rr_hold g%0d: sync_req_o=%b ack_o=%b want 1 0000", g, sync_req_o, ack_o);
            end
            tick();
            sync_ack_i = 1'b1;
            #1;
            checks++;
            if (ack_o !== (4'b0001 << exp_gnt)) begin
                errors++;
                $display("FAIL rr_ack g%0d: ack_o=%b want %b", g, ack_o, 4'b0001 << exp_gnt);
            end
            tick();
            sync_ack_i = 1'b0;
        end
        req_i = 4'b0000;
    endtask

    // Grantee 1 drops in cycle 3, ack in cycle 6: no ack_o, then requester 2 next.
    task automatic test_drop();
        req_i = 4'b0110;
        #1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 3) req_i = 4'b0100;
            sync_ack_i = (c == 6);
            #1;
            checks++;
            if (sync_req_o !== 1'b1 || gnt_idx_o !== 2'd1 || ack_o !== 4'b0000) begin
                errors++;
                $display("FAIL drop_hold c%0d: sync_req_o=%b gnt=%0d ack_o=%b want 1 1 0000",
                         c, sync_req_o, gnt_idx_o, ack_o);
            end
        end
        tick();
        sync_ack_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_gap: busy_o=%b want 0", busy_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || gnt_idx_o !== 2'd2) begin
            errors++;
            $display("FAIL drop_next: busy_o=%b gnt_idx_o=%0d want 1 2", busy_o, gnt_idx_o);
        end
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 4'b0100) begin
            errors++;
            $display("FAIL drop_next_ack: ack_o=%b want 0100", ack_o);
        end
        tick();
        sync_ack_i = 1'b0;
        req_i      = 4'b0000;
    endtask

    // No ack for 12 cycles: timeout_o from cycle 9 on, late ack in cycle 13 clears.
    task automatic test_timeout();
        logic exp_to;
        req_i = 4'b0001;
        #1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_to = (c >= 9);
            checks++;
            if (busy_o !== 1'b1 || gnt_idx_o !== 2'd0 || timeout_o !== exp_to) begin
                errors++;
                $display("FAIL timeout c%0d: busy_o=%b gnt=%0d timeout_o=%b want 1 0 %b",
                         c, busy_o, gnt_idx_o, timeout_o, exp_to);
            end
        end
        tick();
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if (timeout_o !== 1'b1 || ack_o !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_late_ack: timeout_o=%b ack_o=%b want 1 0001", timeout_o, ack_o);
        end
        tick();
        sync_ack_i = 1'b0;
        req_i      = 4'b0000;
        #1;
        checks++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: timeout_o=%b busy_o=%b want 0 0", timeout_o, busy_o);
        end
    endtask

    // Reset mid-handshake clears outputs at once; afterwards the scan starts at 0.
    task automatic test_reset_mid();
        req_i = 4'b0100;
        #1;
        tick();
        checks++;
        if (busy_o !== 1'b1 || gnt_idx_o !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_pre: busy_o=%b gnt_idx_o=%0d want 1 2", busy_o, gnt_idx_o);
        end
        #2;
        rst_ni     = 1'b0;
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if ({sync_req_o, busy_o, timeout_o, ack_o, gnt_idx_o} !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_async: req=%b busy=%b to=%b ack=%b gnt=%0d want all 0",
                     sync_req_o, busy_o, timeout_o, ack_o, gnt_idx_o);
        end
        sync_ack_i = 1'b0;
        req_i      = 4'b1000;
        tick();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: busy_o=%b want 0", busy_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b1 || gnt_idx_o !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_gnt: busy_o=%b gnt_idx_o=%0d want 1 3", busy_o, gnt_idx_o);
        end
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 4'b1000) begin
            errors++;
            $display("FAIL rstmid_ack: ack_o=%b want 1000", ack_o);
        end
        tick();
        sync_ack_i = 1'b0;
        req_i      = 4'b0000;
    endtask

    // Acks arriving in IDLE are ignored, with or without pending requests.
    task automatic test_stray_ack();
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 4'b0000 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle: ack_o=%b busy_o=%b want 0000 0", ack_o, busy_o);
        end
        tick();
        req_i = 4'b1111;
        #1;
        checks++;
        if (ack_o !== 4'b0000 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_with_req: ack_o=%b busy_o=%b want 0000 0", ack_o, busy_o);
        end
        tick();
        sync_ack_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b1 || gnt_idx_o !== 2'd0 || ack_o !== 4'b0000) begin
            errors++;
            $display("FAIL stray_gnt: busy_o=%b gnt=%0d ack_o=%b want 1 0 0000", busy_o, gnt_idx_o, ack_o);
        end
        sync_ack_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 4'b0001) begin
            errors++;
            $display("FAIL stray_final_ack: ack_o=%b want 0001", ack_o);
        end
        tick();
        sync_ack_i = 1'b0;
        req_i      = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_timeout();
        test_reset_mid();
        test_stray_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit: run did not complete within 100000 time units");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/prim_reqack_arb.md
PRIM_REQACK_ARB -- requirements
Module: prim_reqack_arb

Interface
REQ-001 Parameter NumReq, default 4: number of requesters (2..16).
REQ-002 Parameter TimeoutCycles, default 1024: wait-for-ack watchdog threshold; 0 disables the watchdog.
REQ-003 Derived IdxW = max(1, clog2(NumReq)); CntW = max(1, clog2(TimeoutCycles+1)).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  block clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 req_i  input  NumReq  per-requester request, level, held until acked.
REQ-008 ack_o  output  NumReq  per-requester one-cycle ack pulse.
REQ-009 sync_req_o  output  1  request to the shared req/ack synchronizer source side.
REQ-010 sync_ack_i  input  1  one-cycle ack pulse from the synchronizer source side.
REQ-011 gnt_idx_o  output  IdxW  index of the current grantee, valid while busy_o=1.
REQ-012 busy_o  output  1  a handshake is outstanding downstream.
REQ-013 timeout_o  output  1  outstanding handshake exceeded TimeoutCycles.

Function
REQ-014 The FSM SHALL have two states: IDLE and ACTIVE.
REQ-015 In IDLE, if any req_i bit is 1, the block SHALL pick the first set bit at or after rr_ptr (wrapping NumReq-1 -> 0), register it into gnt_idx, and move to ACTIVE on the next edge.
REQ-016 In IDLE with req_i all 0, the block SHALL stay in IDLE; gnt_idx and rr_ptr SHALL hold.
REQ-017 sync_req_o and busy_o SHALL equal (state == ACTIVE), driven from a flop with no combinational path from req_i; latency from req_i rise to sync_req_o is 1 cycle.
REQ-018 In ACTIVE, sync_req_o SHALL stay 1 until sync_ack_i=1, regardless of req_i, including a grantee dropping its request early.
REQ-019 In ACTIVE with sync_ack_i=1: ack_o[gnt_idx] = req_i[gnt_idx] combinationally in that cycle; all other ack_o bits 0; next state IDLE; rr_ptr <= (gnt_idx+1) mod NumReq.
REQ-020 ack_o SHALL be all-zero in IDLE and in ACTIVE without sync_ack_i; at most one ack_o bit is 1 in any cycle.
REQ-021 A grantee dropping req_i before sync_ack_i SHALL receive no ack_o pulse; the downstream handshake still completes and rr_ptr still advances.
REQ-022 sync_ack_i=1 in IDLE SHALL be ignored.
REQ-023 There SHALL be exactly one IDLE cycle between consecutive grants, giving a maximum throughput of one handshake per 2 + downstream-latency cycles.
REQ-024 Round-robin fairness: with all requests held continuously, grants SHALL cycle 0,1,...,NumReq-1,0.
REQ-025 Watchdog counter wd_cnt SHALL clear on entry to ACTIVE, increment each ACTIVE cycle, and saturate at TimeoutCycles.
REQ-026 timeout_o SHALL be 1 when TimeoutCycles != 0, state is ACTIVE, and wd_cnt == TimeoutCycles; it is status only, with no abort, and clears on return to IDLE.

Reset
REQ-027 On rst_ni=0, the block SHALL asynchronously set state=IDLE, gnt_idx=0, rr_ptr=0, wd_cnt=0; sync_req_o=0, busy_o=0, ack_o=0, timeout_o=0, gnt_idx_o=0.
REQ-028 Reset during ACTIVE SHALL drop sync_req_o immediately; the synchronizer is reset in the same domain, so no handshake survives.

Structure
REQ-029 Package prim_reqack_arb_pkg SHALL hold the FSM state typedef (IDLE=1'b0, ACTIVE=1'b1).
REQ-030 The rotate-and-priority-pick logic SHALL be a sub-module prim_reqack_arb_rr (inputs: req vector, rr_ptr; outputs: valid, idx).
REQ-031 The block SHALL contain no latches and no combinational path from sync_ack_i to sync_req_o.

Verification
REQ-032 Single requester: req_i=4'b0100 at cycle 0, sync_ack_i pulse at cycle 5 -> sync_req_o=1 in cycles 1-5, gnt_idx_o=2, ack_o=4'b0100 in cycle 5 only, rr_ptr=3.
REQ-033 All requesters held, downstream acking 2 cycles after each sync_req_o rise -> grant order 0,1,2,3,0, one IDLE cycle between grants.
REQ-034 Grantee 1 drops req_i in cycle 3, ack in cycle 6 -> sync_req_o held through cycle 6, ack_o=0 throughout, next grant to index 2 if requested.
REQ-035 TimeoutCycles=8, no sync_ack_i -> timeout_o rises 8 cycles after ACTIVE entry and stays 1; a late ack clears it and returns to IDLE.
REQ-036 rst_ni asserted mid-ACTIVE -> all outputs 0 in the same cycle; after release with req_i=4'b1000, grant index is 3 (rr_ptr=0 scan).
REQ-037 Stray sync_ack_i pulse in IDLE -> no ack_o, no state change.
